// File: rtl/gray_updown_counter.sv
// Up/down counter whose state register holds a reflected binary Gray code, with wrap or saturate endpoints.
// Defining GRAY_CNT_LOAD_EN adds a synchronous binary load port (load, load_val) that has priority over counting.
module gray_updown_counter #(
   parameter int unsigned WIDTH = 3,
   parameter bit          WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef GRAY_CNT_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`endif
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] bin,
   output logic             tc,
   output logic             evt
);

   localparam logic [WIDTH-1:0] MAX_BIN = '1;

   logic [WIDTH-1:0] q_q, q_d;
   logic             evt_q, evt_d;
   logic             at_max, at_min;

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      bin    = gray2bin(q_q);
      at_max = (bin == MAX_BIN);
      at_min = (bin == '0);
      tc     = en & ((up & at_max) | (~up & at_min));
   end

   always_comb begin
      q_d   = q_q;
      evt_d = 1'b0;
      if (en) begin
         if (up) begin
            if (!at_max) begin
               q_d = bin2gray(bin + WIDTH'(1));
            end else begin
               evt_d = 1'b1;
               if (WRAP) q_d = '0;
            end
         end else begin
            if (!at_min) begin
               q_d = bin2gray(bin - WIDTH'(1));
            end else begin
               evt_d = 1'b1;
               if (WRAP) q_d = bin2gray(MAX_BIN);
            end
         end
      end
`ifdef GRAY_CNT_LOAD_EN
      if (load) begin
         q_d   = bin2gray(load_val);
         evt_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q   <= '0;
         evt_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         evt_q <= evt_d;
      end
   end

   assign q   = q_q;
   assign evt = evt_q;

endmodule
